// File: rtl/ila_capture_core.sv
// rtl/ila_capture_core.sv - parametrised logic-analyser capture engine with circular trace buffer
// Pre-trigger fill, masked level/edge trigger with occurrence count, post-trigger fill, then readout.
module ila_capture_core #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              sample_en_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [DATA_W-1:0] trig_edge_i,
  input  logic [CNT_W-1:0]  trig_cnt_i,
  input  logic [ADDR_W-1:0] pre_trig_i,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic [ADDR_W-1:0] start_addr_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] pre_trig_q;
  logic [CNT_W-1:0]  occ_cnt;
  logic [CNT_W-1:0]  trig_cnt_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] value_q;
  logic [DATA_W-1:0] edge_q;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;

  logic              capturing;
  logic              wr_en;
  logic              match;
  logic [DATA_W-1:0] lvl_err;
  logic [DATA_W-1:0] edge_hit;
  logic [DATA_W-1:0] edge_err;
  logic [CNT_W-1:0]  occ_next;
  logic [CNT_W-1:0]  occ_target;
  logic [ADDR_W-1:0] wr_ptr_next;
  logic [ADDR_W-1:0] pre_next;
  logic [ADDR_W-1:0] post_next;
  logic [ADDR_W-1:0] post_target;

  assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign wr_en     = capturing && sample_en_i && !abort_i;

  // Level bits compare directly; edge bits need a valid previous sample in the requested direction.
  assign lvl_err  = (data_i ^ value_q) & mask_q & ~edge_q;
  assign edge_hit = (value_q & ~prev & data_i) | (~value_q & prev & ~data_i);
  assign edge_err = mask_q & edge_q & ~(edge_hit & {DATA_W{prev_valid}});
  assign match    = (lvl_err == '0) && (edge_err == '0);

  assign occ_next    = occ_cnt + 1'b1;
  assign occ_target  = (trig_cnt_q == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : trig_cnt_q;
  assign wr_ptr_next = wr_ptr + 1'b1;
  assign pre_next    = pre_cnt + 1'b1;
  assign post_next   = post_cnt + 1'b1;
  // DEPTH-1-pre_trig is the bitwise complement within ADDR_W bits.
  assign post_target = ~pre_trig_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      occ_cnt      <= '0;
      pre_trig_q   <= '0;
      trig_cnt_q   <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      edge_q       <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      armed_o      <= 1'b0;
      triggered_o  <= 1'b0;
      done_o       <= 1'b0;
      trig_addr_o  <= '0;
      start_addr_o <= '0;
    end else if (abort_i) begin
      state       <= S_IDLE;
      armed_o     <= 1'b0;
      triggered_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            pre_trig_q  <= pre_trig_i;
            trig_cnt_q  <= trig_cnt_i;
            mask_q      <= trig_mask_i;
            value_q     <= trig_value_i;
            edge_q      <= trig_edge_i;
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            occ_cnt     <= '0;
            prev_valid  <= 1'b0;
            armed_o     <= 1'b1;
            triggered_o <= 1'b0;
            done_o      <= 1'b0;
            state       <= (pre_trig_i == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (sample_en_i) begin
            wr_ptr     <= wr_ptr_next;
            prev       <= data_i;
            prev_valid <= 1'b1;
            pre_cnt    <= pre_next;
            if (pre_next == pre_trig_q) begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (sample_en_i) begin
            wr_ptr     <= wr_ptr_next;
            prev       <= data_i;
            prev_valid <= 1'b1;
            if (match) begin
              occ_cnt <= occ_next;
              if (occ_next == occ_target) begin
                trig_addr_o  <= wr_ptr;
                start_addr_o <= wr_ptr - pre_trig_q;
                armed_o      <= 1'b0;
                triggered_o  <= 1'b1;
                // A full pre-trigger window leaves no room for post samples.
                if (pre_trig_q == '1) begin
                  state  <= S_DONE;
                  done_o <= 1'b1;
                end else begin
                  state <= S_POST;
                end
              end
            end
          end
        end
        S_POST: begin
          if (sample_en_i) begin
            wr_ptr   <= wr_ptr_next;
            post_cnt <= post_next;
            if (post_next == post_target) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: tb/tb_ila_capture_core.sv
// tb/tb_ila_capture_core.sv - scoreboard bench for ila_capture_core
// Small (10x16) and large (32x1024) instances driven with ramp data.
`timescale 1ns/1ps
module tb_ila_capture_core;

  localparam int DW  = 10;
  localparam int AW  = 4;
  localparam int CW  = 8;
  localparam int DW6 = 32;
  localparam int AW6 = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] a_data, a_mask, a_value, a_edge, a_rd_data;
  logic          a_sample_en, a_arm, a_abort, a_rd_en;
  logic          a_armed, a_triggered, a_done;
  logic [CW-1:0] a_trig_cnt;
  logic [AW-1:0] a_pre_trig, a_trig_addr, a_start_addr, a_rd_addr;

  logic [DW6-1:0] b_data, b_mask, b_value, b_edge, b_rd_data;
  logic           b_sample_en, b_arm, b_abort, b_rd_en;
  logic           b_armed, b_triggered, b_done;
  logic [CW-1:0]  b_trig_cnt;
  logic [AW6-1:0] b_pre_trig, b_trig_addr, b_start_addr, b_rd_addr;

  ila_capture_core #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(a_data), .sample_en_i(a_sample_en),
    .arm_i(a_arm), .abort_i(a_abort), .trig_mask_i(a_mask), .trig_value_i(a_value),
    .trig_edge_i(a_edge), .trig_cnt_i(a_trig_cnt), .pre_trig_i(a_pre_trig),
    .armed_o(a_armed), .triggered_o(a_triggered), .done_o(a_done),
    .trig_addr_o(a_trig_addr), .start_addr_o(a_start_addr),
    .rd_addr_i(a_rd_addr), .rd_en_i(a_rd_en), .rd_data_o(a_rd_data)
  );

  ila_capture_core #(.DATA_W(DW6), .ADDR_W(AW6), .CNT_W(CW)) u_dut_big (
    .clk_i(clk), .rst_i(rst), .data_i(b_data), .sample_en_i(b_sample_en),
    .arm_i(b_arm), .abort_i(b_abort), .trig_mask_i(b_mask), .trig_value_i(b_value),
    .trig_edge_i(b_edge), .trig_cnt_i(b_trig_cnt), .pre_trig_i(b_pre_trig),
    .armed_o(b_armed), .triggered_o(b_triggered), .done_o(b_done),
    .trig_addr_o(b_trig_addr), .start_addr_o(b_start_addr),
    .rd_addr_i(b_rd_addr), .rd_en_i(b_rd_en), .rd_data_o(b_rd_data)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_a(input int pt, input logic [DW-1:0] m, input logic [DW-1:0] v,
                       input logic [DW-1:0] e, input int cnt);
    a_pre_trig  = AW'(pt);
    a_mask      = m;
    a_value     = v;
    a_edge      = e;
    a_trig_cnt  = CW'(cnt);
    a_sample_en = 1'b0;
    a_arm       = 1'b1;
    tick();
    a_arm = 1'b0;
    // Disturb the settings inputs; the capture must keep the latched copy.
    a_mask     = '1;
    a_value    = '0;
    a_edge     = '0;
    a_pre_trig = '0;
    a_trig_cnt = 8'd3;
  endtask

  task automatic run_a(input bit toggle, input int arm_at, input int abort_post, output int cycles);
    int k = 0;
    int post_seen = 0;
    bit phase = 1'b1;
    bit trig_before;
    cycles = 0;
    while (!a_done && cycles < 200 && !(abort_post > 0 && post_seen >= abort_post)) begin
      a_sample_en = toggle ? phase : 1'b1;
      a_data      = DW'(k);
      a_arm       = (arm_at >= 0) && (k == arm_at) && a_sample_en;
      trig_before = a_triggered;
      tick();
      a_arm = 1'b0;
      if (a_sample_en) begin
        k++;
        if (trig_before) post_seen++;
      end
      phase = !phase;
      cycles++;
    end
    a_sample_en = 1'b0;
  endtask

  task automatic read_window_a(input string tag, input int start, input int first_k);
    for (int i = 0; i < 16; i++) begin
      a_rd_addr = AW'(start + i);
      a_rd_en   = 1'b1;
      exp_q.push_back(32'(first_k + i));
      tick();
      check(tag, 32'(a_rd_data), exp_q.pop_front());
    end
    a_rd_en = 1'b0;
  endtask

  task automatic check_result_a(input string tag, input int cyc, input int exp_cyc,
                                input int exp_trig, input int exp_start);
    check({tag, "_done"}, 32'(a_done), 1);
    check({tag, "_trig"}, 32'(a_triggered), 1);
    check({tag, "_armed"}, 32'(a_armed), 0);
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_trig_addr"}, 32'(a_trig_addr), 32'(exp_trig));
    check({tag, "_start_addr"}, 32'(a_start_addr), 32'(exp_start));
  endtask

  initial begin
    int cyc;
    int b_k;
    int b_cyc;
    int b_addrs[3];
    int b_exp[3];

    rst = 1'b1;
    a_data = '0; a_mask = '0; a_value = '0; a_edge = '0; a_sample_en = 1'b0;
    a_arm = 1'b0; a_abort = 1'b0; a_rd_en = 1'b0; a_trig_cnt = '0; a_pre_trig = '0; a_rd_addr = '0;
    b_data = '0; b_mask = '0; b_value = '0; b_edge = '0; b_sample_en = 1'b0;
    b_arm = 1'b0; b_abort = 1'b0; b_rd_en = 1'b0; b_trig_cnt = '0; b_pre_trig = '0; b_rd_addr = '0;
    tick();
    tick();
    check("rst_armed", 32'(a_armed), 0);
    check("rst_triggered", 32'(a_triggered), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_trig_addr", 32'(a_trig_addr), 0);
    check("rst_start_addr", 32'(a_start_addr), 0);
    check("rst_rd_data", 32'(a_rd_data), 0);
    rst = 1'b0;
    tick();

    // 1: level trigger on bit0, pre_trig 4
    arm_a(4, 10'h001, 10'h001, 10'h000, 1);
    check("s1_armed", 32'(a_armed), 1);
    check("s1_trig_early", 32'(a_triggered), 0);
    run_a(1'b0, -1, 0, cyc);
    check_result_a("s1", cyc, 17, 5, 1);
    read_window_a("s1_rd", 1, 1);
    a_rd_addr = 4'd7;
    tick();
    check("s1_rd_hold", 32'(a_rd_data), 16);

    // 2: falling edge on bit3, second occurrence
    arm_a(8, 10'h008, 10'h000, 10'h008, 2);
    run_a(1'b0, -1, 0, cyc);
    check_result_a("s2", cyc, 40, 0, 8);
    read_window_a("s2_rd", 8, 24);

    // 3: scenario 1 with a 1,0,1,0 qualifier
    arm_a(4, 10'h001, 10'h001, 10'h000, 1);
    run_a(1'b1, -1, 0, cyc);
    check_result_a("s3", cyc, 33, 5, 1);
    read_window_a("s3_rd", 1, 1);

    // 4: abort after three post samples, then re-arm
    arm_a(4, 10'h001, 10'h001, 10'h000, 1);
    run_a(1'b0, -1, 3, cyc);
    check("s4_in_post", 32'(a_triggered), 1);
    check("s4_not_done", 32'(a_done), 0);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("s4_abort_armed", 32'(a_armed), 0);
    check("s4_abort_trig", 32'(a_triggered), 0);
    check("s4_abort_done", 32'(a_done), 0);
    arm_a(4, 10'h001, 10'h001, 10'h000, 1);
    run_a(1'b0, -1, 0, cyc);
    check_result_a("s4_rearm", cyc, 17, 5, 1);
    read_window_a("s4_rd", 1, 1);
    a_arm = 1'b1;
    a_abort = 1'b1;
    tick();
    a_arm = 1'b0;
    a_abort = 1'b0;
    a_sample_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_data = DW'(i);
      tick();
    end
    a_sample_en = 1'b0;
    check("s4_arm_abort_armed", 32'(a_armed), 0);
    check("s4_arm_abort_done", 32'(a_done), 0);

    // 5: full pre-trigger window, mask 0, trig_cnt 0 acts as 1, arm in PRE ignored
    arm_a(15, 10'h000, 10'h000, 10'h000, 0);
    run_a(1'b0, 3, 0, cyc);
    check_result_a("s5", cyc, 16, 15, 0);
    read_window_a("s5_rd", 0, 0);

    // 6: wide instance, asynchronous reset mid-WAIT
    b_pre_trig = 10'd512; b_mask = '1; b_value = 32'd700; b_edge = '0; b_trig_cnt = 8'd1;
    b_arm = 1'b1;
    tick();
    b_arm = 1'b0;
    b_sample_en = 1'b1;
    for (int k = 0; k < 600; k++) begin
      b_data = DW6'(k);
      tick();
    end
    check("s6_pre_rst_armed", 32'(b_armed), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("s6_rst_armed", 32'(b_armed), 0);
    check("s6_rst_a_done", 32'(a_done), 0);
    check("s6_rst_a_trig_addr", 32'(a_trig_addr), 0);
    tick();
    check("s6_rst_hold", 32'(b_armed), 0);
    rst = 1'b0;
    b_sample_en = 1'b0;
    b_arm = 1'b1;
    tick();
    b_arm = 1'b0;
    b_k = 0;
    b_cyc = 0;
    while (!b_done && b_cyc < 3000) begin
      b_sample_en = 1'b1;
      b_data = DW6'(b_k);
      tick();
      b_k++;
      b_cyc++;
    end
    b_sample_en = 1'b0;
    check("s6_done", 32'(b_done), 1);
    check("s6_cycles", 32'(b_cyc), 1212);
    check("s6_trig_addr", 32'(b_trig_addr), 700);
    check("s6_start_addr", 32'(b_start_addr), 188);
    b_addrs = '{188, 700, 187};
    b_exp   = '{188, 700, 1211};
    for (int i = 0; i < 3; i++) begin
      b_rd_addr = AW6'(b_addrs[i]);
      b_rd_en = 1'b1;
      exp_q.push_back(32'(b_exp[i]));
      tick();
      check("s6_rd", b_rd_data, exp_q.pop_front());
    end
    b_rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
